// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks a one-hot phase enable through NUM_PHASES
// phases per instruction in continuous (RUN) or single-step (STEP) mode.
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int COUNT_W    = 16
) (
    input  logic                          clkIn,
    input  logic                          resetN,
    input  logic                          runIn,
    input  logic                          stepIn,
    input  logic                          stallIn,
    input  logic                          abortIn,
    output logic [NUM_PHASES-1:0]         phaseEn,
    output logic [$clog2(NUM_PHASES)-1:0] phaseIdx,
    output logic                          busy,
    output logic                          cycleDone,
    output logic [COUNT_W-1:0]            instrCount
);

    localparam int IDX_W = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } stateT;

    stateT                 stateR,      nextStateS;
    logic [NUM_PHASES-1:0] phaseEnR,    nextPhaseEnS;
    logic [IDX_W-1:0]      phaseIdxR,   nextPhaseIdxS;
    logic [COUNT_W-1:0]    instrCountR, nextInstrCountS;
    logic                  busyR;
    logic                  cycleDoneS;

    // Completion is combinational so a stall or abort in the last phase suppresses it at once.
    always_comb begin
        cycleDoneS = phaseEnR[NUM_PHASES-1] & ~stallIn & ~abortIn;
    end

    // Next-state, next-phase and counter decode; abort outranks stall and completion.
    always_comb begin
        nextStateS      = stateR;
        nextPhaseEnS    = phaseEnR;
        nextPhaseIdxS   = phaseIdxR;
        nextInstrCountS = instrCountR;
        case (stateR)
            IDLE: begin
                if (abortIn) begin
                    nextStateS = IDLE;
                end else if (runIn) begin
                    nextStateS    = RUN;
                    nextPhaseEnS  = NUM_PHASES'(1);
                    nextPhaseIdxS = IDX_W'(0);
                end else if (stepIn) begin
                    nextStateS    = STEP;
                    nextPhaseEnS  = NUM_PHASES'(1);
                    nextPhaseIdxS = IDX_W'(0);
                end else begin
                    nextStateS = IDLE;
                end
            end
            RUN, STEP: begin
                if (abortIn) begin
                    nextStateS    = IDLE;
                    nextPhaseEnS  = NUM_PHASES'(0);
                    nextPhaseIdxS = IDX_W'(0);
                end else if (stallIn) begin
                    nextStateS = stateR;
                end else if (cycleDoneS) begin
                    nextInstrCountS = instrCountR + COUNT_W'(1);
                    if ((stateR == RUN) && runIn) begin
                        nextStateS    = RUN;
                        nextPhaseEnS  = NUM_PHASES'(1);
                        nextPhaseIdxS = IDX_W'(0);
                    end else begin
                        nextStateS    = IDLE;
                        nextPhaseEnS  = NUM_PHASES'(0);
                        nextPhaseIdxS = IDX_W'(0);
                    end
                end else begin
                    nextPhaseEnS  = phaseEnR << 1;
                    nextPhaseIdxS = phaseIdxR + IDX_W'(1);
                end
            end
            default: begin
                nextStateS    = IDLE;
                nextPhaseEnS  = NUM_PHASES'(0);
                nextPhaseIdxS = IDX_W'(0);
            end
        endcase
    end

    // State, phase and counter registers; busy is registered alongside the state.
    always_ff @(posedge clkIn or negedge resetN) begin
        if (!resetN) begin
            stateR      <= IDLE;
            phaseEnR    <= NUM_PHASES'(0);
            phaseIdxR   <= IDX_W'(0);
            instrCountR <= COUNT_W'(0);
            busyR       <= 1'b0;
        end else begin
            stateR      <= nextStateS;
            phaseEnR    <= nextPhaseEnS;
            phaseIdxR   <= nextPhaseIdxS;
            instrCountR <= nextInstrCountS;
            busyR       <= (nextStateS != IDLE);
        end
    end

    assign phaseEn    = phaseEnR;
    assign phaseIdx   = phaseIdxR;
    assign busy       = busyR;
    assign cycleDone  = cycleDoneS;
    assign instrCount = instrCountR;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus random
// stimulus, checked against an integer-level behavioural model.
module tb_phase_sequencer;

    localparam int NP = 4;
    localparam int CW = 8;   // narrow counter keeps the wrap test short

    logic          clkIn = 1'b0;
    logic          resetN = 1'b0;
    logic          runIn = 1'b0, stepIn = 1'b0, stallIn = 1'b0, abortIn = 1'b0;
    logic [NP-1:0] phaseEn;
    logic [1:0]    phaseIdx;
    logic          busy, cycleDone;
    logic [CW-1:0] instrCount;

    int nVectors = 0;
    int nMiscompares = 0;

    // model: mode 0=idle 1=run 2=step, phase number, completed count
    int mMode = 0, mPhase = 0, mCount = 0;

    phase_sequencer #(.NUM_PHASES(NP), .COUNT_W(CW)) dut (
        .clkIn(clkIn), .resetN(resetN), .runIn(runIn), .stepIn(stepIn),
        .stallIn(stallIn), .abortIn(abortIn), .phaseEn(phaseEn),
        .phaseIdx(phaseIdx), .busy(busy), .cycleDone(cycleDone),
        .instrCount(instrCount)
    );

    always #5 clkIn = ~clkIn;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        if (obs !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic modelDone();
        return (mMode != 0) && (mPhase == NP - 1) && !stallIn && !abortIn;
    endfunction

    task automatic checkAll(input string tag);
        logic [31:0] expEn;
        expEn = (mMode != 0) ? (32'd1 << mPhase) : 32'd0;
        checkVal({tag, ".phaseEn"}, 32'(phaseEn), expEn);
        checkVal({tag, ".phaseIdx"}, 32'(phaseIdx), (mMode != 0) ? 32'(mPhase) : 32'd0);
        checkVal({tag, ".busy"}, 32'(busy), 32'(mMode != 0));
        checkVal({tag, ".cycleDone"}, 32'(cycleDone), 32'(modelDone()));
        checkVal({tag, ".instrCount"}, 32'(instrCount), 32'(mCount));
    endtask

    task automatic modelStep();
        if (mMode == 0) begin
            if (!abortIn && runIn) begin mMode = 1; mPhase = 0; end
            else if (!abortIn && stepIn) begin mMode = 2; mPhase = 0; end
        end else if (abortIn) begin
            mMode = 0; mPhase = 0;
        end else if (!stallIn) begin
            if (mPhase == NP - 1) begin
                mCount = (mCount + 1) % (1 << CW);
                if (mMode == 1 && runIn) mPhase = 0;
                else begin mMode = 0; mPhase = 0; end
            end else begin
                mPhase++;
            end
        end
    endtask

    // apply inputs for one cycle, check at the falling edge, advance the model at the rising edge
    task automatic cyc(input logic r, input logic s, input logic st, input logic a, input string tag);
        runIn = r; stepIn = s; stallIn = st; abortIn = a;
        @(negedge clkIn);
        checkAll(tag);
        @(posedge clkIn);
        modelStep();
        #1;
    endtask

    initial begin
        int guard;
        // reset held
        #12;
        checkAll("reset");
        @(negedge clkIn);
        checkAll("resetHeld");
        resetN = 1'b1;
        @(posedge clkIn); #1;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        // continuous run, 12 cycles -> three instructions
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, "run12");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "drain");
        checkVal("run12.count", 32'(instrCount), 32'd3);
        // single step, runIn low afterwards, step pulses ignored while busy
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "stepGo");
        for (int i = 0; i < 5; i++) cyc(1'b0, (i == 1), 1'b0, 1'b0, "step");
        checkVal("step.count", 32'(instrCount), 32'd4);
        // stall three cycles on phase 1
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "stallGo");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "stallP0");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "stall");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "stallEnd");
        // runIn dropped while on phase 1
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "dropGo");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "dropP0");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "drop");
        // abort with stall on phase 2
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "abortGo");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "abortP0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "abortP1");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, "abort");
        checkVal("abort.busy", 32'(busy), 32'd0);
        checkVal("abort.phaseEn", 32'(phaseEn), 32'd0);
        // abort in idle blocks run and step
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "idleAbort");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "idleAbortChk");
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), "rand");
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, "settle");
        // counter wrap: run until the counter reaches all-ones, then one more instruction
        guard = 0;
        while (mCount != (1 << CW) - 1 && guard < 5000) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, "toWrap");
            guard++;
        end
        checkVal("wrap.guard", 32'(guard < 5000), 32'd1);
        guard = 0;
        while (mCount != 0 && guard < 20) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, "wrap");
            guard++;
        end
        checkVal("wrap.count", 32'(instrCount), 32'd0);
        // reset pulse mid-phase clears outputs immediately
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "preReset");
        @(negedge clkIn); #2;
        resetN = 1'b0;
        runIn = 1'b0;
        #1;
        mMode = 0; mPhase = 0; mCount = 0;
        checkAll("asyncReset");
        @(posedge clkIn); #1;
        resetN = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "postReset");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "postResetStep");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "postResetP0");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001: Parameter NUM_PHASES, default 4, number of execution phases per instruction; legal range 2..16.
REQ-002: Parameter COUNT_W, default 16, width of the retired-instruction counter.
REQ-003: clkIn  input  1  single system clock; all state updates on rising edge.
REQ-004: resetN  input  1  asynchronous, active-low reset.
REQ-005: runIn  input  1  level; request continuous instruction execution.
REQ-006: stepIn  input  1  single-cycle pulse; request exactly one instruction when idle.
REQ-007: stallIn  input  1  level; hold the current phase (datapath not ready).
REQ-008: abortIn  input  1  level; terminate the current instruction immediately.
REQ-009: phaseEn  output  NUM_PHASES  one-hot phase enable for the datapath; all-zero when idle.
REQ-010: phaseIdx  output  $clog2(NUM_PHASES)  binary index of the active phase; 0 when idle.
REQ-011: busy  output  1  high whenever the state is not IDLE.
REQ-012: cycleDone  output  1  high in the cycle the last phase completes.
REQ-013: instrCount  output  COUNT_W  number of completed instructions.

Function
REQ-014: The states SHALL be IDLE, RUN and STEP, and phaseEn SHALL be generated as a registered one-hot clock enable, never as a derived clock.
REQ-015: In IDLE, phaseEn SHALL be all-zero and phaseIdx SHALL be 0.
REQ-016: IDLE with runIn=1 SHALL go to RUN, and phaseEn SHALL be 1 (phase 0) in the next cycle.
REQ-017: IDLE with runIn=0 and stepIn=1 SHALL go to STEP, with phaseEn=1 in the next cycle; runIn SHALL take priority over stepIn.
REQ-018: In RUN or STEP with stallIn=0, the active phase SHALL advance k -> k+1 each cycle, giving NUM_PHASES cycles per instruction.
REQ-019: When stallIn=1, phaseEn, phaseIdx, state and instrCount SHALL all hold, and cycleDone SHALL be 0.
REQ-020: cycleDone SHALL equal phaseEn[NUM_PHASES-1] AND NOT stallIn AND NOT abortIn (combinational).
REQ-021: On each edge where cycleDone=1, instrCount SHALL increment by 1 modulo 2^COUNT_W (all-ones wraps to 0).
REQ-022: At a completion edge in RUN with runIn=1, the sequencer SHALL wrap to phase 0 with no idle gap.
REQ-023: At a completion edge in RUN with runIn=0, the sequencer SHALL go to IDLE; deasserting runIn mid-instruction halts only at the instruction boundary.
REQ-024: At a completion edge in STEP, the sequencer SHALL always go to IDLE, regardless of runIn.
REQ-025: stepIn SHALL be ignored in RUN and STEP, and SHALL NOT be queued.
REQ-026: abortIn=1 in RUN or STEP SHALL force IDLE at the next edge (phaseEn=0) without incrementing instrCount; abortIn SHALL take priority over stallIn and completion.
REQ-027: abortIn=1 in IDLE SHALL block all transitions out of IDLE.
REQ-028: phaseEn SHALL be one-hot or all-zero in every cycle, and phaseIdx SHALL always match phaseEn.

Reset
REQ-029: While resetN=0, the outputs SHALL be: state=IDLE, phaseEn=0, phaseIdx=0, busy=0, cycleDone=0, instrCount=0.
REQ-030: Reset assertion mid-instruction SHALL clear all outputs asynchronously, with no completion counted.
REQ-031: After resetN deasserts, the first transition SHALL occur on the first rising edge with runIn or stepIn sampled high.

Verification
REQ-032: runIn held 1 for 12 cycles, NUM_PHASES=4 -> phaseEn sequence 1,2,4,8 repeating; cycleDone every 4th cycle; instrCount=3.
REQ-033: stepIn pulse from IDLE, runIn=0 -> phaseEn 1,2,4,8 then 0; busy high for exactly 4 cycles; instrCount +1.
REQ-034: stallIn=1 for 3 cycles while phaseEn=2 -> phaseEn stays 2 for 3 extra cycles; the instruction takes 7 cycles; cycleDone fires exactly once.
REQ-035: runIn dropped while phaseEn=2 -> phases 4 and 8 complete, then IDLE; instrCount +1.
REQ-036: abortIn while phaseEn=4 together with stallIn=1 -> phaseEn=0 next cycle; instrCount unchanged; busy=0.
REQ-037: instrCount preloaded near 0xFFFF by running 65535 instructions, then one more instruction -> instrCount=0x0000; a resetN pulse mid-phase -> all outputs 0 immediately.
